hangman_game_ctrl: RTL

Game-sequencing controller for the blind-hangman user project. It sits between the raw player inputs taken from the user IO pads and the status outputs driven back onto the pads. It holds the secret word and the set of letters already guessed. It scores each guess by scanning the word one letter position per cycle, and tracks misses until the player wins or loses.

---
 rtl/hangman_game_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hangman_game_ctrl.sv
// hangman_game_ctrl: game sequencer for the blind-hangman user project.
// Holds the secret word and the set of guessed letters. Each guess is scored
// by scanning one word position per clock. Misses are counted until the
// player wins or loses.
// Ports:
//   wb_clk_i, wb_rst_n   - clock, asynchronous active-low reset
//   load_i, letter_i     - word load strobe; letter code (0..25 = A..Z)
//   guess_i, new_game_i  - raw buttons, asynchronous to wb_clk_i
//   mask_o               - revealed positions (bit 0 = first letter)
//   misses_o, state_o    - miss count, state code
//   busy_o, dup_o        - scan in progress, repeated-guess pulse
//   win_o, lose_o        - game result
module hangman_game_ctrl #(
  parameter int unsigned WORD_LEN   = 6,
  parameter int unsigned MAX_MISSES = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                load_i,
  input  logic [4:0]          letter_i,
  input  logic                guess_i,
  input  logic                new_game_i,
  output logic [WORD_LEN-1:0] mask_o,
  output logic [2:0]          misses_o,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                dup_o,
  output logic                win_o,
  output logic                lose_o
);

  localparam int unsigned LW    = 5;
  localparam int unsigned NLET  = 26;
  localparam int unsigned MW    = 3;
  localparam int unsigned PTR_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam int unsigned IDX_W = $clog2(WORD_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       word_q [WORD_LEN];
  logic [LW-1:0]       word_d [WORD_LEN];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WORD_LEN-1:0] mask_q, mask_d;
  logic [MW-1:0]       misses_q, misses_d;
  logic [NLET-1:0]     guessed_q, guessed_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [LW-1:0]       cur_q, cur_d;
  logic                dup_d;
  logic                busy_q, dup_q, win_q, lose_q;

  // [0] first sync flop, [1] second sync flop, [2] previous synced value
  logic [2:0]          guess_sync_q, ng_sync_q;
  logic                guess_pulse_q, ng_pulse_q;

  logic                letter_ok;
  logic [MW-1:0]       misses_inc;
  logic [PTR_W-1:0]    scan_pos;

  assign letter_ok  = (letter_i < LW'(NLET));
  assign misses_inc = misses_q + MW'(1);
  assign scan_pos   = idx_q[PTR_W-1:0];

  // Button synchronizers and rising-edge pulse generators
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      guess_sync_q  <= '0;
      ng_sync_q     <= '0;
      guess_pulse_q <= 1'b0;
      ng_pulse_q    <= 1'b0;
    end else begin
      guess_sync_q  <= {guess_sync_q[1], guess_sync_q[0], guess_i};
      ng_sync_q     <= {ng_sync_q[1], ng_sync_q[0], new_game_i};
      guess_pulse_q <= guess_sync_q[1] & ~guess_sync_q[2];
      ng_pulse_q    <= ng_sync_q[1] & ~ng_sync_q[2];
    end
  end

  // State and datapath registers; status outputs registered from next state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      word_q    <= '{default: '0};
      ptr_q     <= '0;
      mask_q    <= '0;
      misses_q  <= '0;
      guessed_q <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      cur_q     <= '0;
      busy_q    <= 1'b0;
      dup_q     <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      misses_q  <= misses_d;
      guessed_q <= guessed_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      cur_q     <= cur_d;
      busy_q    <= (state_d == CHECK);
      dup_q     <= dup_d;
      win_q     <= (state_d == WIN);
      lose_q    <= (state_d == LOSE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    ptr_d     = ptr_q;
    mask_d    = mask_q;
    misses_d  = misses_q;
    guessed_d = guessed_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    cur_d     = cur_q;
    dup_d     = 1'b0;

    if (ng_pulse_q) begin
      // New game overrides everything; the word itself is kept until reloaded
      state_d   = IDLE;
      ptr_d     = '0;
      mask_d    = '0;
      misses_d  = '0;
      guessed_d = '0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (load_i && letter_ok) begin
            word_d[ptr_q] = letter_i;
            if (ptr_q == PTR_W'(WORD_LEN - 1)) begin
              ptr_d     = '0;
              mask_d    = '0;
              misses_d  = '0;
              guessed_d = '0;
              state_d   = PLAY;
            end else begin
              ptr_d   = ptr_q + PTR_W'(1);
              state_d = LOAD;
            end
          end
        end
        PLAY: begin
          if (guess_pulse_q && letter_ok) begin
            if (guessed_q[letter_i]) begin
              dup_d = 1'b1;
            end else begin
              cur_d               = letter_i;
              guessed_d[letter_i] = 1'b1;
              hit_d               = 1'b0;
              idx_d               = '0;
              state_d             = CHECK;
            end
          end
        end
        CHECK: begin
          if (idx_q < IDX_W'(WORD_LEN)) begin
            // Scan one position per cycle against the latched guess
            if (word_q[scan_pos] == cur_q) begin
              mask_d[scan_pos] = 1'b1;
              hit_d            = 1'b1;
            end
            idx_d = idx_q + IDX_W'(1);
          end else if (hit_q) begin
            state_d = (&mask_q) ? WIN : PLAY;
          end else begin
            misses_d = misses_inc;
            state_d  = (misses_inc == MW'(MAX_MISSES)) ? LOSE : PLAY;
          end
        end
        default: begin
          // WIN and LOSE hold until a new game
        end
      endcase
    end
  end

  assign mask_o   = mask_q;
  assign misses_o = misses_q;
  assign state_o  = state_q;
  assign busy_o   = busy_q;
  assign dup_o    = dup_q;
  assign win_o    = win_q;
  assign lose_o   = lose_q;

endmodule
